// File: rtl/lsu_mem_initiator.sv
// Load/store unit bridging the execute stage to a word-wide data memory.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module lsu_mem_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RMW   = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] merge_r;
    logic [DATA_W-1:0] merge_nxt_s;
    logic [DATA_W-1:0] load_data_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic              accept_s;
    logic              req_err_s;
    logic              mem_active_s;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            2'b01:   m = lo[0];
            2'b10:   m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign accept_s  = req_valid & req_ready_r;
    assign req_err_s = ~f3_legal(req_we, req_funct3) | misaligned(req_funct3[1:0], req_addr[1:0]);

    // Next-state decode of the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = ST_RESP;
                end else if (!req_we) begin
                    state_nxt_s = ST_LOAD;
                end else if (req_funct3[1:0] == 2'b10) begin
                    state_nxt_s = ST_STORE;
                end else begin
                    state_nxt_s = ST_RMW;
                end
            end
            ST_LOAD:  state_nxt_s = ST_RESP;
            ST_RMW:   state_nxt_s = ST_STORE;
            ST_STORE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        byte_s      = 8'h00;
        half_s      = 16'h0000;
        load_data_s = {DATA_W{1'b0}};
        case (addr_r[1:0])
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            2'b11:   byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_r[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        case (funct3_r)
            3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
            3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
            3'b010:  load_data_s = mem_rdata;
            3'b100:  load_data_s = {24'h000000, byte_s};
            3'b101:  load_data_s = {16'h0000, half_s};
            default: load_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Merge store data into the word read back during RMW.
    always_comb begin
        merge_nxt_s = mem_rdata;
        if (funct3_r[1:0] == 2'b00) begin
            case (addr_r[1:0])
                2'b00:   merge_nxt_s[7:0]   = wdata_r[7:0];
                2'b01:   merge_nxt_s[15:8]  = wdata_r[7:0];
                2'b10:   merge_nxt_s[23:16] = wdata_r[7:0];
                2'b11:   merge_nxt_s[31:24] = wdata_r[7:0];
                default: merge_nxt_s = mem_rdata;
            endcase
        end else if (funct3_r[1:0] == 2'b01) begin
            if (addr_r[1]) begin
                merge_nxt_s[31:16] = wdata_r[15:0];
            end else begin
                merge_nxt_s[15:0] = wdata_r[15:0];
            end
        end else begin
            merge_nxt_s = mem_rdata;
        end
    end

    // State register and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Request capture on acceptance; held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end
    end

    // Merge register loaded in the RMW read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_RMW) begin
            merge_r <= merge_nxt_s;
        end
    end

    // Response data/error update only on entry to RESP, held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
        end else if (state_nxt_s == ST_RESP) begin
            resp_err_r   <= (state_r == ST_IDLE);
            resp_rdata_r <= (state_r == ST_LOAD) ? load_data_s : {DATA_W{1'b0}};
        end
    end

    // Memory port is decoded purely from registered state so reset kills a write at once.
    assign mem_active_s = (state_r == ST_LOAD) | (state_r == ST_RMW) | (state_r == ST_STORE);
    assign mem_rw       = (state_r == ST_STORE) & we_r;
    assign mem_addr     = mem_active_s ? {addr_r[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
    assign mem_wdata    = (state_r != ST_STORE)     ? {DATA_W{1'b0}} :
                          (funct3_r[1:0] == 2'b10)  ? wdata_r : merge_r;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: directed test-plan cases, reset mid-store,
// then randomized traffic checked against a word-array reference model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
        int          idx;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_load = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          acc_edge = 0;
    int          wr_cnt = 0;
    logic        prev_rv = 1'b0;
    logic [31:0] last_rdata = 32'd0;

    lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_rw) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (req_valid && req_ready) acc_edge <= edge_cnt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: RISC-V load/store semantics on a plain word array.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output exp_t e);
        int          k;
        bit          legal;
        bit          mis;
        logic [31:0] w, b, h, mask;
        k       = a % 4;
        e.idx   = (a % 256) / 4;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.wr    = 0;
        w       = ref_mem[e.idx];
        legal   = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        mis     = ((f3 % 4) == 1 && (k % 2) != 0) || ((f3 % 4) == 2 && k != 0);
        if (!legal || mis) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            b = (w >> (8 * k)) & 32'hFF;
            h = (w >> (8 * (k - k % 2))) & 32'hFFFF;
            case (f3)
                3'd0:    e.rdata = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
                3'd1:    e.rdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
                3'd2:    e.rdata = w;
                3'd4:    e.rdata = b;
                default: e.rdata = h;
            endcase
        end else begin
            e.wr = 1;
            if (f3 == 3'd2) begin
                e.lat = 2;
                ref_mem[e.idx] = wd;
            end else begin
                e.lat = 3;
                if (f3 == 3'd0) mask = 32'hFF << (8 * k);
                else            mask = 32'hFFFF << (8 * k);
                ref_mem[e.idx] = (w & ~mask) | ((wd << (8 * k)) & mask);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every response and checks handshake timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            wr_cnt  = 0;
            prev_rv = 1'b0;
        end else begin
            if (prev_rv) chk("ready_after_resp", req_ready, 1'b1);
            if (mem_rw) wr_cnt++;
            if (resp_valid) begin
                chk("ready_low_in_resp", req_ready, 1'b0);
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", resp_err, e.err);
                    chk("latency", 32'(edge_cnt - acc_edge), 32'(e.lat));
                    chk("write_cycles", 32'(wr_cnt), 32'(e.wr));
                    chk("mem_word", mem[e.idx], ref_mem[e.idx]);
                end
                last_rdata = resp_rdata;
                wr_cnt = 0;
            end
            prev_rv = resp_valid;
        end
    end

    task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit garbage);
        exp_t e;
        int   t = 0;
        while (!req_ready) begin
            if (garbage) begin
                req_valid  = 1'b1;
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            @(negedge clk);
            t++;
            if (t > 100) begin
                chk("ready_timeout", 32'd1, 32'd0);
                return;
            end
        end
        model(we, f3, a, wd, e);
        sbq.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        if (garbage) begin
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_we    = 1'($urandom);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        req_valid = 1'b0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_mem_rw"}, mem_rw, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[4]  = 32'h8899AABB;
        init_mem[8]  = 32'h11223344;
        init_mem[12] = 32'hCAFEF00D;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        mem_load = 1'b1;
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        // Loads on word 0x10.
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0); drain(); chk("lw_0x10",  last_rdata, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h11, 32'd0, 1'b0); drain(); chk("lb_0x11",  last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h11, 32'd0, 1'b0); drain(); chk("lbu_0x11", last_rdata, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h12, 32'd0, 1'b0); drain(); chk("lh_0x12",  last_rdata, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h12, 32'd0, 1'b0); drain(); chk("lhu_0x12", last_rdata, 32'h00008899);

        // Read-modify-write stores on word 0x20.
        do_req(1'b1, 3'b000, 32'h21, 32'h000000EE, 1'b0); drain();
        do_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1'b0); drain();
        chk("rmw_word_0x20", mem[8], 32'hBEEFEE44);

        // Misaligned and illegal accesses.
        do_req(1'b0, 3'b010, 32'h13, 32'd0, 1'b0); drain();
        do_req(1'b1, 3'b001, 32'h21, 32'h5555AAAA, 1'b0); drain();
        do_req(1'b0, 3'b011, 32'h24, 32'd0, 1'b0); drain();
        do_req(1'b1, 3'b011, 32'h28, 32'h12345678, 1'b0); drain();
        chk("err_word_0x20", mem[8], 32'hBEEFEE44);

        // Reset while in STORE must suppress the write.
        t = 0;
        while (!req_ready && t < 10) begin @(negedge clk); t++; end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("store_before_reset", mem_rw, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mem_rw_drop_on_reset", mem_rw, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_store_reset");
        chk("word_0x30_kept", mem[12], 32'hCAFEF00D);

        // Randomized traffic, some with busy-cycle garbage on the request bus.
        for (int n = 0; n < 300; n++) begin
            bit       we;
            bit [2:0] f3;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            if (!we && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
            do_req(we, f3, 32'($urandom_range(0, 255)), $urandom, 1'($urandom));
        end
        drain();

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
